sdram_arbiter: RTL

Shares the single 16-bit Avalon-MM SDRAM port between two masters: port 0 (the sobel engine) and port 1 (the HPS frame loader/readback bridge). It grants one master at a time with a bounded round-robin hold, tracks outstanding reads in an in-order owner FIFO, and routes each `readdatavalid` back to the master that issued the read. It sits between the filter datapaths and the SDRAM controller slave.

---
 rtl/sdram_arbiter_pkg.sv | 13 +
 rtl/sdram_arbiter_tag_fifo.sv | 55 +++++
 rtl/sdram_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared types and constants for the two-master SDRAM arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_t;

    localparam logic M_SOBEL = 1'b0;
    localparam logic M_HOST  = 1'b1;

endpackage

// File: rtl/sdram_arbiter_tag_fifo.sv
// In-order owner-id FIFO: one entry per read in flight, popped per returned beat.
module tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic                     i_push_id,
    input  logic                     i_pop,
    output logic                     o_head_id,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head_id = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_id;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master Avalon-MM SDRAM arbiter: round-robin grant with bounded hold,
// in-order read-response routing through an owner-tag FIFO.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int MAX_OUTST = 8,
    parameter int HOLD      = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       m0_read_n,
    input  logic                       m0_write_n,
    input  logic [ADDR_W-1:0]          m0_address,
    input  logic [1:0]                 m0_byteenable,
    input  logic [DATA_W-1:0]          m0_writedata,
    output logic                       m0_waitrequest,
    output logic                       m0_readdatavalid,
    output logic [DATA_W-1:0]          m0_readdata,
    input  logic                       m1_read_n,
    input  logic                       m1_write_n,
    input  logic [ADDR_W-1:0]          m1_address,
    input  logic [1:0]                 m1_byteenable,
    input  logic [DATA_W-1:0]          m1_writedata,
    output logic                       m1_waitrequest,
    output logic                       m1_readdatavalid,
    output logic [DATA_W-1:0]          m1_readdata,
    output logic                       s_read_n,
    output logic                       s_write_n,
    output logic                       s_chipselect,
    output logic [ADDR_W-1:0]          s_address,
    output logic [1:0]                 s_byteenable,
    output logic [DATA_W-1:0]          s_writedata,
    input  logic                       s_waitrequest,
    input  logic                       s_readdatavalid,
    input  logic [DATA_W-1:0]          s_readdata,
    output logic [1:0]                 grant,
    output logic [$clog2(MAX_OUTST):0] outstanding,
    output logic                       err_orphan
);

    localparam int HW = $clog2(HOLD + 1);

    arb_state_t       r_state;
    logic [1:0]       r_grant;
    logic             r_last;
    logic [HW-1:0]    r_hold;
    logic             r_orphan;

    logic             w_req0;
    logic             w_req1;
    logic             w_own;
    logic             w_active;
    logic             w_sel_read_n;
    logic             w_sel_write_n;
    logic             w_sel_rd;
    logic             w_sel_wr;
    logic             w_stall;
    logic             w_wait;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_orphan;
    logic             w_head;
    logic             w_full;
    logic             w_empty;
    logic [HW-1:0]    w_hold_nxt;
    logic             w_hold_done;
    logic [$clog2(MAX_OUTST):0] w_count;

    assign w_req0   = ~m0_read_n | ~m0_write_n;
    assign w_req1   = ~m1_read_n | ~m1_write_n;
    assign w_own    = (r_state == G1);
    assign w_active = (r_state != IDLE);

    assign w_sel_read_n  = w_own ? m1_read_n  : m0_read_n;
    assign w_sel_write_n = w_own ? m1_write_n : m0_write_n;

    // Read+write together forwards only the write.
    assign w_sel_wr = w_active & ~w_sel_write_n;
    assign w_sel_rd = w_active & ~w_sel_read_n & w_sel_write_n;
    assign w_stall  = w_sel_rd & w_full;
    assign w_wait   = s_waitrequest | w_stall;
    assign w_accept = (w_sel_rd | w_sel_wr) & ~w_wait;
    assign w_push   = w_accept & w_sel_rd;

    assign s_chipselect = 1'b1;
    assign s_read_n     = ~(w_sel_rd & ~w_stall);
    assign s_write_n    = ~w_sel_wr;
    assign s_address    = w_own ? m1_address    : m0_address;
    assign s_byteenable = w_own ? m1_byteenable : m0_byteenable;
    assign s_writedata  = w_own ? m1_writedata  : m0_writedata;

    assign m0_waitrequest = (r_state == G0) ? w_wait : 1'b1;
    assign m1_waitrequest = (r_state == G1) ? w_wait : 1'b1;

    assign w_pop    = s_readdatavalid & ~w_empty;
    assign w_orphan = s_readdatavalid & w_empty;

    assign m0_readdatavalid = w_pop & (w_head == M_SOBEL);
    assign m1_readdatavalid = w_pop & (w_head == M_HOST);
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    assign grant       = r_grant;
    assign outstanding = w_count;
    assign err_orphan  = r_orphan;

    // Saturating count including the transfer accepted this cycle, so the
    // grant yields right after the HOLD-th transfer rather than one later.
    assign w_hold_nxt  = (r_hold == HW'(HOLD)) ? r_hold : r_hold + HW'(w_accept);
    assign w_hold_done = (w_hold_nxt == HW'(HOLD));

    tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (w_push),
        .i_push_id (w_own),
        .i_pop     (w_pop),
        .o_head_id (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_last   <= M_HOST;
            r_hold   <= '0;
            r_orphan <= 1'b0;
        end else begin
            if (w_orphan) begin
                r_orphan <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_hold <= '0;
                    if (w_req0 && (!w_req1 || r_last == M_HOST)) begin
                        r_state <= G0;
                        r_grant <= 2'b01;
                        r_last  <= M_SOBEL;
                    end else if (w_req1) begin
                        r_state <= G1;
                        r_grant <= 2'b10;
                        r_last  <= M_HOST;
                    end
                end
                G0: begin
                    if (!w_req0 || (w_hold_done && w_req1)) begin
                        r_hold <= '0;
                        if (w_req1) begin
                            r_state <= G1;
                            r_grant <= 2'b10;
                            r_last  <= M_HOST;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                        end
                    end else begin
                        r_hold <= w_hold_nxt;
                    end
                end
                G1: begin
                    if (!w_req1 || (w_hold_done && w_req0)) begin
                        r_hold <= '0;
                        if (w_req0) begin
                            r_state <= G0;
                            r_grant <= 2'b01;
                            r_last  <= M_SOBEL;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                        end
                    end else begin
                        r_hold <= w_hold_nxt;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                    r_hold  <= '0;
                end
            endcase
        end
    end

endmodule
